// File: rtl/rans_ctrl_if.sv
// rans_ctrl_if -- stream bundle between the rANS controller and its neighbours.
//
// Carries the frequency-table stream (tbl_*), the symbol stream (sym_*) and
// the encoder-lane drive (freq_wr_o, freq_o, cum_freq_o, symb_o, en_o).
// Signal suffixes are from the controller's point of view:
//   slave  : the controller (consumes *_i, drives *_o)
//   master : the source/sink around it (drives *_i, consumes *_o)
interface rans_ctrl_if #(
    parameter int RESOLUTION   = 10,
    parameter int SYMBOL_WIDTH = 8
);
    logic                    tbl_valid_i;
    logic [RESOLUTION:0]     tbl_freq_i;
    logic                    tbl_ready_o;

    logic                    sym_valid_i;
    logic [SYMBOL_WIDTH-1:0] sym_i;
    logic                    sym_last_i;
    logic                    sym_ready_o;

    logic                    freq_wr_o;
    logic [RESOLUTION:0]     freq_o;
    logic [RESOLUTION-1:0]   cum_freq_o;
    logic [SYMBOL_WIDTH-1:0] symb_o;
    logic                    en_o;

    modport master (
        output tbl_valid_i, tbl_freq_i,
        input  tbl_ready_o,
        output sym_valid_i, sym_i, sym_last_i,
        input  sym_ready_o,
        input  freq_wr_o, freq_o, cum_freq_o, symb_o, en_o
    );

    modport slave (
        input  tbl_valid_i, tbl_freq_i,
        output tbl_ready_o,
        input  sym_valid_i, sym_i, sym_last_i,
        output sym_ready_o,
        output freq_wr_o, freq_o, cum_freq_o, symb_o, en_o
    );
endinterface

// File: rtl/rans_ctrl.sv
// rans_ctrl -- job controller for a rANS encoder.
//
// A job loads a 2^SYMBOL_WIDTH-entry frequency table (one entry per handshake,
// symbol order), writing each entry and its running cumulative frequency into
// the encoder lanes, optionally verifies that the table sums to 2^RESOLUTION,
// then forwards symbols to the encoder one per cycle until the last one,
// waits DRAIN_CYCLES cycles and pulses done_o.
//
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   start_i         begin a job (honoured only when idle or in error)
//   abort_i         abandon the job; returns to idle next cycle
//   busy_o          job in progress (LOAD/CHECK/RUN/DRAIN)
//   done_o          one-cycle job-complete pulse
//   err_o           table-sum error, held until start_i or abort_i
//   bus             rans_ctrl_if.slave: table stream, symbol stream,
//                   encoder-lane outputs
//
// Build option:
//   RANS_CTRL_TBL_CHECK_EN  when defined, CHECK compares the table sum with
//                           2^RESOLUTION and enters ERR on a difference; when
//                           undefined, CHECK always proceeds to RUN and err_o
//                           is tied low.
module rans_ctrl #(
    parameter int RESOLUTION   = 10,
    parameter int SYMBOL_WIDTH = 8,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic       abort_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    rans_ctrl_if.slave bus
);
    // Wide enough that a bad table can never wrap back onto the exact total.
    localparam int ACC_W = RESOLUTION + SYMBOL_WIDTH + 1;
    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DRAIN_LAST =
        CNT_W'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_RUN,
        S_DRAIN,
        S_DONE,
        S_ERR
    } state_e;

    state_e                  state_q;
    logic [SYMBOL_WIDTH-1:0] idx_q;
    logic [ACC_W-1:0]        acc_q;
    logic [ACC_W-1:0]        acc_d;
    logic [CNT_W-1:0]        drain_q;
    logic                    freq_wr_q;
    logic [RESOLUTION:0]     freq_q;
    logic [RESOLUTION-1:0]   cum_q;
    logic [SYMBOL_WIDTH-1:0] symb_q;
    logic                    en_q;
    logic                    tbl_hs;
    logic                    sym_hs;
    logic                    sum_ok;

    // Ready is gated by abort_i in the same cycle so an aborting cycle can
    // never complete a handshake.
    assign bus.tbl_ready_o = (state_q == S_LOAD) && !abort_i;
    assign bus.sym_ready_o = (state_q == S_RUN) && !abort_i;
    assign tbl_hs          = bus.tbl_valid_i && bus.tbl_ready_o;
    assign sym_hs          = bus.sym_valid_i && bus.sym_ready_o;
    assign acc_d           = acc_q + ACC_W'(bus.tbl_freq_i);

`ifdef RANS_CTRL_TBL_CHECK_EN
    localparam logic [ACC_W-1:0] TBL_TOTAL = ACC_W'(2 ** RESOLUTION);
    assign sum_ok = (acc_q == TBL_TOTAL);
    // ERR is only left through start_i or abort_i, both of which must clear
    // the flag, so the flag is exactly "in ERR".
    assign err_o  = (state_q == S_ERR);
`else
    assign sum_ok = 1'b1;
    assign err_o  = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            drain_q   <= '0;
            freq_wr_q <= 1'b0;
            freq_q    <= '0;
            cum_q     <= '0;
            symb_q    <= '0;
            en_q      <= 1'b0;
        end else begin
            freq_wr_q <= 1'b0;
            en_q      <= 1'b0;
            if (abort_i) begin
                state_q <= S_IDLE;
            end else begin
                unique case (state_q)
                    S_IDLE, S_ERR: begin
                        if (start_i) begin
                            state_q <= S_LOAD;
                            idx_q   <= '0;
                            acc_q   <= '0;
                        end
                    end
                    S_LOAD: begin
                        if (tbl_hs) begin
                            freq_wr_q <= 1'b1;
                            freq_q    <= bus.tbl_freq_i;
                            cum_q     <= acc_q[RESOLUTION-1:0];
                            symb_q    <= idx_q;
                            acc_q     <= acc_d;
                            idx_q     <= idx_q + SYMBOL_WIDTH'(1);
                            if (&idx_q) begin
                                state_q <= S_CHECK;
                            end
                        end
                    end
                    S_CHECK: begin
                        state_q <= sum_ok ? S_RUN : S_ERR;
                    end
                    S_RUN: begin
                        if (sym_hs) begin
                            en_q   <= 1'b1;
                            symb_q <= bus.sym_i;
                            if (bus.sym_last_i) begin
                                drain_q <= '0;
                                state_q <= (DRAIN_CYCLES == 0) ? S_DONE : S_DRAIN;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (drain_q == DRAIN_LAST) begin
                            state_q <= S_DONE;
                        end else begin
                            drain_q <= drain_q + CNT_W'(1);
                        end
                    end
                    S_DONE: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.freq_wr_o  = freq_wr_q;
    assign bus.freq_o     = freq_q;
    assign bus.cum_freq_o = cum_q;
    assign bus.symb_o     = symb_q;
    assign bus.en_o       = en_q;
    assign done_o         = (state_q == S_DONE);
    assign busy_o         = (state_q == S_LOAD) || (state_q == S_CHECK) ||
                            (state_q == S_RUN)  || (state_q == S_DRAIN);
endmodule

// File: tb/tb_rans_ctrl.sv
// tb_rans_ctrl -- self-checking bench for rans_ctrl.
//
// A table of job records (entry-0 frequency, remaining frequency, expected
// error, expected cumulative frequency of the last entry) is applied in a
// loop; each job's writes are compared with prefix sums computed from the
// table, and accepted symbols with the list that was sent. Hand-written
// sequences cover abort during LOAD and reset during RUN.
module tb_rans_ctrl;
    localparam int RES   = 10;
    localparam int SW    = 8;
    localparam int DC    = 4;
    localparam int N     = 1 << SW;
    localparam int TOTAL = 1 << RES;

    typedef struct {
        int f0;
        int frest;
        bit exp_err;
        int exp_last_cum;
    } tvec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic abort;
    logic busy;
    logic done;
    logic err;

    rans_ctrl_if #(.RESOLUTION(RES), .SYMBOL_WIDTH(SW)) bus ();

    rans_ctrl #(
        .RESOLUTION  (RES),
        .SYMBOL_WIDTH(SW),
        .DRAIN_CYCLES(DC)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .start_i(start),
        .abort_i(abort),
        .busy_o (busy),
        .done_o (done),
        .err_o  (err),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int wr_cum[$];
    int wr_freq[$];
    int wr_sym[$];
    int en_sym[$];
    int tbl_f[N];
    int syms[$];
    tvec_t vecs[6];

    // Observe the encoder lanes 1 time unit after every rising edge.
    always @(posedge clk) begin
        #1;
        if (bus.freq_wr_o === 1'b1) begin
            wr_cum.push_back(int'(bus.cum_freq_o));
            wr_freq.push_back(int'(bus.freq_o));
            wr_sym.push_back(int'(bus.symb_o));
        end
        if (bus.en_o === 1'b1) begin
            en_sym.push_back(int'(bus.symb_o));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_mon();
        wr_cum.delete();
        wr_freq.delete();
        wr_sym.delete();
        en_sym.delete();
    endtask

    function automatic longint all_outputs();
        return longint'({bus.tbl_ready_o, bus.sym_ready_o, bus.freq_wr_o,
                         bus.freq_o, bus.cum_freq_o, bus.symb_o, bus.en_o,
                         busy, done, err});
    endfunction

    task automatic start_job();
        start = 1'b1;
        step();
        start = 1'b0;
        check("load_ready_after_start", bus.tbl_ready_o, 1);
        check("busy_in_load", busy, 1);
    endtask

    // Stream the whole table with random gaps and random (ignored) start_i.
    task automatic load_table();
        int k = 0;
        int g = 0;
        while (k < N && g < 2000) begin
            bit v;
            v = ($urandom_range(0, 3) != 0);
            bus.tbl_valid_i = v;
            bus.tbl_freq_i  = (RES + 1)'(tbl_f[k]);
            start           = ($urandom_range(0, 1) == 1);
            #1;
            if (v && bus.tbl_ready_o) k++;
            step();
            g++;
        end
        bus.tbl_valid_i = 1'b0;
        start           = 1'b0;
        check("load_accepted", k, N);
    endtask

    // Compare captured writes with the table's running prefix sums.
    task automatic verify_table(input int exp_last_cum, output int sum);
        int acc = 0;
        int bad = 0;
        check("wr_count", wr_cum.size(), N);
        if (wr_cum.size() == N) begin
            for (int k = 0; k < N; k++) begin
                if (wr_cum[k] != (acc % TOTAL) || wr_freq[k] != tbl_f[k] || wr_sym[k] != k)
                    bad++;
                acc += tbl_f[k];
            end
            check("wr_content_bad_entries", bad, 0);
            check("first_cum", wr_cum[0], 0);
            check("last_cum", wr_cum[N-1], exp_last_cum);
        end
        sum = 0;
        for (int k = 0; k < N; k++) sum += tbl_f[k];
    endtask

    task automatic run_syms(input bit alt_gap);
        int k   = 0;
        int g   = 0;
        int cnt = 0;
        int bad = 0;
        while (k < syms.size() && g < 1000) begin
            bit v;
            v = alt_gap ? ((g % 2) == 0) : ($urandom_range(0, 2) != 0);
            bus.sym_valid_i = v;
            bus.sym_i       = SW'(syms[k]);
            bus.sym_last_i  = (k == syms.size() - 1);
            #1;
            if (v && bus.sym_ready_o) k++;
            step();
            g++;
        end
        bus.sym_valid_i = 1'b0;
        bus.sym_last_i  = 1'b0;
        check("sym_accepted", k, syms.size());
        while (done !== 1'b1 && cnt < 20) begin
            step();
            cnt++;
        end
        check("done_latency", cnt, DC);
        check("en_count", en_sym.size(), syms.size());
        if (en_sym.size() == syms.size()) begin
            for (int i = 0; i < syms.size(); i++)
                if (en_sym[i] != syms[i]) bad++;
            check("en_symbol_bad", bad, 0);
        end
        step();
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
    endtask

    initial begin
        vecs[0] = '{4,    4, 1'b0, 1020};
        vecs[1] = '{5,    4, 1'b1, 1021};
        vecs[2] = '{259,  3, 1'b0, 1021};
        vecs[3] = '{0,    4, 1'b1, 1016};
        vecs[4] = '{1024, 0, 1'b0, 0};
        vecs[5] = '{1024, 1, 1'b1, 254};

        rst_n           = 1'b0;
        start           = 1'b0;
        abort           = 1'b0;
        bus.tbl_valid_i = 1'b0;
        bus.tbl_freq_i  = '0;
        bus.sym_valid_i = 1'b0;
        bus.sym_i       = '0;
        bus.sym_last_i  = 1'b0;
        #3;
        check("reset_outputs", all_outputs(), 0);
        step();
        rst_n = 1'b1;
        step();
        check("idle_not_busy", busy, 0);

        for (int i = 0; i < 6; i++) begin
            int  sum;
            bit  exp_err;
            tbl_f[0] = vecs[i].f0;
            for (int k = 1; k < N; k++) tbl_f[k] = vecs[i].frest;
`ifdef RANS_CTRL_TBL_CHECK_EN
            exp_err = vecs[i].exp_err;
`else
            exp_err = 1'b0;
`endif
            clear_mon();
            start_job();
            load_table();
            verify_table(vecs[i].exp_last_cum, sum);
            check("busy_in_check", busy, 1);
            step();
            check("err_after_check", err, exp_err);
            check("sym_ready_after_check", bus.sym_ready_o, !exp_err);
            if (exp_err) begin
                check("err_not_busy", busy, 0);
                check("err_table_sum_off", (sum != TOTAL), 1);
                step();
                check("err_held", err, 1);
                if (i % 2 == 1) begin
                    start = 1'b1;
                    step();
                    start = 1'b0;
                    check("err_cleared_by_start", err, 0);
                    check("load_after_err", bus.tbl_ready_o, 1);
                    abort = 1'b1;
                    step();
                    abort = 1'b0;
                    check("abort_from_load_busy", busy, 0);
                end else begin
                    abort = 1'b1;
                    step();
                    abort = 1'b0;
                    check("err_cleared_by_abort", err, 0);
                    check("abort_from_err_busy", busy, 0);
                end
            end else begin
                syms.delete();
                if (i == 0) begin
                    syms.push_back(8'h41);
                    syms.push_back(8'h42);
                    syms.push_back(8'h43);
                    run_syms(1'b1);
                end else begin
                    int n;
                    n = $urandom_range(1, 12);
                    for (int s = 0; s < n; s++) syms.push_back(int'($urandom_range(0, N - 1)));
                    run_syms(1'b0);
                end
            end
        end

        // Abort at entry 100 with valid held high.
        for (int k = 0; k < N; k++) tbl_f[k] = 4;
        clear_mon();
        start_job();
        for (int k = 0; k < 100; k++) begin
            bus.tbl_valid_i = 1'b1;
            bus.tbl_freq_i  = (RES + 1)'(tbl_f[k]);
            step();
        end
        bus.tbl_valid_i = 1'b1;
        abort           = 1'b1;
        start           = 1'b1;
        #1;
        check("abort_ready_low", bus.tbl_ready_o, 0);
        step();
        abort = 1'b0;
        start = 1'b0;
        check("abort_busy_low", busy, 0);
        repeat (5) step();
        check("abort_wr_count", wr_cum.size(), 100);
        check("abort_ready_stays_low", bus.tbl_ready_o, 0);
        bus.tbl_valid_i = 1'b0;

        // Reset in the middle of RUN.
        clear_mon();
        start_job();
        load_table();
        begin
            int sum;
            verify_table(1020, sum);
        end
        step();
        check("run_ready", bus.sym_ready_o, 1);
        bus.sym_valid_i = 1'b1;
        bus.sym_i       = SW'(7);
        step();
        bus.sym_i = SW'(8);
        step();
        check("run_en_before_reset", en_sym.size(), 2);
        bus.sym_i = SW'(9);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrun_reset_outputs", all_outputs(), 0);
        step();
        step();
        rst_n           = 1'b1;
        bus.tbl_valid_i = 1'b1;
        repeat (10) step();
        check("no_en_after_reset", en_sym.size(), 2);
        check("no_wr_after_reset", wr_cum.size(), N);
        check("sym_ready_after_reset", bus.sym_ready_o, 0);
        check("busy_after_reset", busy, 0);
        bus.sym_valid_i = 1'b0;
        bus.tbl_valid_i = 1'b0;

        // A fresh job still works after the reset.
        clear_mon();
        start_job();
        load_table();
        begin
            int sum;
            verify_table(1020, sum);
        end
        step();
        syms.delete();
        syms.push_back(8'h10);
        syms.push_back(8'hff);
        run_syms(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rans_ctrl.md
RANS_CTRL -- requirements
Module: rans_ctrl

Interface
REQ-001 SHALL have parameter RESOLUTION, default 10, probability resolution in bits (table total 2^RESOLUTION).
REQ-002 SHALL have parameter SYMBOL_WIDTH, default 8, symbol width; table depth 2^SYMBOL_WIDTH.
REQ-003 SHALL have parameter DRAIN_CYCLES, default 4, cycles waited after last symbol issue before done.
REQ-004 SHALL use a single clock and an asynchronous, active-low reset: clk_i  in  1  clock; rst_ni  in  1  async active-low reset.
REQ-005 start_i  in  1  begin a job (table load, then encode).
REQ-006 abort_i  in  1  abandon current job.
REQ-007 tbl_valid_i  in  1  / tbl_freq_i  in  RESOLUTION+1  / tbl_ready_o  out  1: frequency-table stream, entries in symbol order 0..2^SYMBOL_WIDTH-1.
REQ-008 sym_valid_i  in  1  / sym_i  in  SYMBOL_WIDTH  / sym_last_i  in  1  / sym_ready_o  out  1: symbol stream.
REQ-009 freq_wr_o  out  1  / freq_o  out  RESOLUTION+1  / cum_freq_o  out  RESOLUTION  / symb_o  out  SYMBOL_WIDTH  / en_o  out  1: drive encoder lanes.
REQ-010 busy_o  out  1  state not IDLE/DONE/ERR; done_o  out  1  one-cycle job-complete pulse; err_o  out  1  table-sum error, held.

Function
REQ-011 SHALL implement states IDLE, LOAD, CHECK, RUN, DRAIN, DONE, ERR.
REQ-012 IDLE or ERR with start_i=1 SHALL go to LOAD, clearing entry index, accumulator and err_o; start_i SHALL be ignored in other states.
REQ-013 tbl_ready_o SHALL be 1 only in LOAD with abort_i=0; sym_ready_o SHALL be 1 only in RUN with abort_i=0.
REQ-014 Each table handshake SHALL produce, next cycle, freq_wr_o=1, freq_o=tbl_freq_i, cum_freq_o=accumulator[RESOLUTION-1:0] before adding, symb_o=entry index; otherwise freq_wr_o=0.
REQ-015 Accumulator SHALL be RESOLUTION+SYMBOL_WIDTH+1 bits (no wrap); index SHALL increment per handshake; handshake on index 2^SYMBOL_WIDTH-1 SHALL go to CHECK.
REQ-016 CHECK SHALL last one cycle: accumulator==2^RESOLUTION -> RUN, else -> ERR with err_o=1.
REQ-017 Each RUN symbol handshake SHALL produce, next cycle, en_o=1 and symb_o=sym_i; en_o=0 otherwise; throughput one symbol per cycle.
REQ-018 Handshake with sym_last_i=1 SHALL go to DRAIN; DRAIN SHALL hold DRAIN_CYCLES cycles then enter DONE.
REQ-019 DONE SHALL last one cycle with done_o=1, then IDLE.
REQ-020 abort_i=1 in any state SHALL go to IDLE next cycle, accept no handshake that cycle, and clear err_o; abort_i wins over start_i.
REQ-021 Gaps in tbl_valid_i/sym_valid_i SHALL stall progress without emitting writes or enables.

Reset
REQ-022 rst_ni=0 SHALL asynchronously force IDLE, index and accumulator 0, and all outputs 0 (tbl_ready_o, sym_ready_o, freq_wr_o, freq_o, cum_freq_o, symb_o, en_o, busy_o, done_o, err_o).
REQ-023 Reset mid-job SHALL discard the job; after deassertion no write or enable SHALL occur until a new start_i.

Configuration
REQ-024 Macro RANS_CTRL_TBL_CHECK_EN defined: CHECK compares sum per REQ-016.
REQ-025 Macro undefined: CHECK SHALL always go to RUN, ERR unreachable, err_o tied 0.

Verification (RESOLUTION=10, SYMBOL_WIDTH=8, DRAIN_CYCLES=4, macro defined)
REQ-026 start, 256 entries freq=4 back-to-back -> 256 freq_wr_o pulses, entry k cum_freq_o=4k (entry 255 -> 1020), CHECK -> RUN, sym_ready_o=1.
REQ-027 entry 0 freq=5, rest 4 (sum 1025) -> err_o=1, state ERR, sym_ready_o=0; start_i -> err_o=0, LOAD.
REQ-028 RUN, symbols 0x41,0x42,0x43 (last on 0x43) with one-cycle valid gap -> three en_o pulses with matching symb_o, done_o exactly 4 cycles after DRAIN entry, then IDLE.
REQ-029 abort_i at entry 100 of LOAD with tbl_valid_i=1 -> tbl_ready_o=0 that cycle, no further freq_wr_o, busy_o=0 next cycle.
REQ-030 rst_ni low mid-RUN -> all outputs 0 immediately; sym_valid_i=1 after release -> no en_o until new start_i.
